// File: rtl/wifi_rx_pkg.sv
// Shared defaults and width helpers for the WiFi RX word FIFO.
package wifi_rx_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 8;
  localparam int LVL_W_DEF      = $clog2(DEPTH_DEF) + 1;

  // Pointer width for a power-of-two depth; level needs one bit more.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/wifi_rx_fifo_if.sv
// Deserializer/bus-side bundle of the RX FIFO: write strobe, read port, control and status.
interface wifi_rx_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  logic                    wr_valid;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic                    flush;
  logic [$clog2(DEPTH):0]  thresh;
  logic                    en_irq;
  logic                    clear_irq;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic [$clog2(DEPTH):0]  level;
  logic                    empty;
  logic                    full;
  logic                    overflow;
  logic                    irq;

  modport master (
    output wr_valid, wr_data, rd_en, flush, thresh, en_irq, clear_irq,
    input  rd_data, rd_valid, level, empty, full, overflow, irq
  );

  modport slave (
    input  wr_valid, wr_data, rd_en, flush, thresh, en_irq, clear_irq,
    output rd_data, rd_valid, level, empty, full, overflow, irq
  );
endinterface

// File: rtl/wifi_rx_fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read. Array itself is never cleared.
module wifi_rx_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
  end

  // A read and write to the same slot (full with concurrent read/write) returns the old word.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= ram[raddr];
  end
endmodule

// File: rtl/wifi_rx_fifo.sv
// RX word FIFO between deserializer and bus: pointers, level, overflow and threshold interrupt.
module wifi_rx_fifo
  import wifi_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  wifi_rx_fifo_if.slave  bus
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             empty, full;
  logic             do_rd, do_wr, drop;
  logic             overflow, irq, rd_vld;
  logic             irq_cond;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));

  // Flush overrides everything; a write into a full FIFO only lands when a read frees a slot.
  assign do_rd = bus.rd_en && !empty && !bus.flush;
  assign do_wr = bus.wr_valid && (!full || do_rd) && !bus.flush;
  assign drop  = bus.wr_valid && full && !do_rd && !bus.flush;

  assign irq_cond = bus.en_irq &&
                    (((bus.thresh != '0) && (level >= bus.thresh)) || overflow);

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rd_vld <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      rd_vld <= do_rd;
      case ({do_wr, do_rd})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush)  overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (bus.clear_irq)  overflow <= 1'b0;
  end

  // Clear wins for one cycle; a persisting condition re-arms on the following edge.
  always_ff @(posedge clk) begin
    if (reset || bus.flush)  irq <= 1'b0;
    else if (bus.clear_irq)  irq <= 1'b0;
    else if (irq_cond)       irq <= 1'b1;
  end

  wifi_rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PTR_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (do_wr),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .re    (do_rd),
    .raddr (rd_ptr),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid = rd_vld;
  assign bus.level    = level;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.overflow = overflow;
  assign bus.irq      = irq;
endmodule

// File: tb/tb_wifi_rx_fifo.sv
// Directed bench for wifi_rx_fifo; read data checked by a scoreboard queue drained by a monitor.
module tb_wifi_rx_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wifi_rx_fifo_if #(.DATA_WIDTH(32), .DEPTH(8)) bus ();

  wifi_rx_fifo #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_valid = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0; bus.clear_irq = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    bus.wr_valid = 1'b1; bus.wr_data = d; tick(); bus.wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] d);
    bus.rd_en = 1'b1; exp_q.push_back(d); tick(); bus.rd_en = 1'b0;
  endtask

  // Monitor: every rd_valid must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rd_valid: got data %h expected no read", bus.rd_data);
        end else begin
          chk("rd_data", bus.rd_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    idle();
    bus.wr_data = '0; bus.thresh = '0; bus.en_irq = 1'b0;
    tick(); tick();
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_irq", 32'(bus.irq), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_rd_data", bus.rd_data, 0);
    reset = 1'b0;

    // Scenario 1: fill and drain in order
    for (int i = 1; i <= 8; i++) wr(32'h11111111 * i);
    chk("s1_full", 32'(bus.full), 1);
    chk("s1_level", 32'(bus.level), 8);
    for (int i = 1; i <= 8; i++) rd(32'h11111111 * i);
    chk("s1_empty", 32'(bus.empty), 1);
    tick();

    // Scenario 2: drop on full sets overflow
    for (int i = 0; i < 8; i++) wr(32'hA0 + i);
    wr(32'hDEADBEEF);
    chk("s2_ovf", 32'(bus.overflow), 1);
    chk("s2_level", 32'(bus.level), 8);
    for (int i = 0; i < 8; i++) rd(32'hA0 + i);
    bus.clear_irq = 1'b1; tick(); bus.clear_irq = 1'b0;
    chk("s2_ovf_clr", 32'(bus.overflow), 0);
    chk("s2_irq_blocked", 32'(bus.irq), 0);

    // Scenario 3: read and write together while full
    for (int i = 0; i < 8; i++) wr(32'hB0 + i);
    bus.wr_valid = 1'b1; bus.wr_data = 32'hC0; bus.rd_en = 1'b1;
    exp_q.push_back(32'hB0);
    tick(); idle();
    chk("s3_level", 32'(bus.level), 8);
    chk("s3_ovf", 32'(bus.overflow), 0);
    for (int i = 1; i < 8; i++) rd(32'hB0 + i);
    rd(32'hC0);
    chk("s3_empty", 32'(bus.empty), 1);

    // Scenario 4: threshold interrupt and clear priority
    bus.thresh = 4; bus.en_irq = 1'b1;
    for (int i = 0; i < 4; i++) wr(32'hD0 + i);
    chk("s4_irq_lat", 32'(bus.irq), 0);
    tick();
    chk("s4_irq_set", 32'(bus.irq), 1);
    bus.clear_irq = 1'b1; tick(); bus.clear_irq = 1'b0;
    chk("s4_irq_clr", 32'(bus.irq), 0);
    tick();
    chk("s4_irq_rearm", 32'(bus.irq), 1);
    bus.en_irq = 1'b0; tick();
    chk("s4_irq_hold_dis", 32'(bus.irq), 1);
    bus.en_irq = 1'b1;
    bus.clear_irq = 1'b1; rd(32'hD0); bus.clear_irq = 1'b0;
    chk("s4_level3", 32'(bus.level), 3);
    chk("s4_irq_off", 32'(bus.irq), 0);
    tick();
    chk("s4_irq_stays", 32'(bus.irq), 0);
    bus.thresh = 0;
    for (int i = 1; i < 4; i++) rd(32'hD0 + i);

    // Scenario 5: no fall-through, then flush with overflow and irq pending
    bus.wr_valid = 1'b1; bus.wr_data = 32'hE0; bus.rd_en = 1'b1;
    tick(); idle();
    chk("s5_no_rdv", 32'(bus.rd_valid), 0);
    chk("s5_level1", 32'(bus.level), 1);
    for (int i = 1; i < 8; i++) wr(32'hE0 + i);
    wr(32'hE8);
    tick();
    chk("s5_ovf_irq", 32'(bus.irq), 1);
    bus.flush = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 32'hE9; bus.rd_en = 1'b1;
    tick(); idle();
    chk("s5_fl_level", 32'(bus.level), 0);
    chk("s5_fl_ovf", 32'(bus.overflow), 0);
    chk("s5_fl_irq", 32'(bus.irq), 0);
    chk("s5_fl_rdv", 32'(bus.rd_valid), 0);
    bus.en_irq = 1'b0;
    wr(32'hF0);
    rd(32'hF0);

    // Scenario 6: reset with stored words and a read in flight
    for (int i = 0; i < 5; i++) wr(32'h50 + i);
    chk("s6_level5", 32'(bus.level), 5);
    bus.rd_en = 1'b1; reset = 1'b1;
    tick(); idle(); reset = 1'b0;
    chk("s6_level", 32'(bus.level), 0);
    chk("s6_empty", 32'(bus.empty), 1);
    chk("s6_rdv", 32'(bus.rd_valid), 0);
    chk("s6_rd_data", bus.rd_data, 0);
    wr(32'h60);
    rd(32'h60);
    tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
